inport_irq: RTL and testbench
=============================

# inport_irq

Memory-mapped input port with interrupt generation for the PacoBlaze3 I/O bus: the read-direction counterpart of the `outport` peripheral. Synchronises 8 external pins, exposes their live level, latches rising edges into sticky flags that clear on read, and drives the CPU `interrupt` input from a maskable OR of those flags. Its registered, zero-when-unaddressed `value_out` is OR-combined with other peripherals onto the CPU `in_port`.

## Interface
- `ADDR`, 8'h01: port id returning synchronised pin levels.
- `EADDR`, 8'h02: port id returning edge flags; reading clears the returned flags.
- `MADDR`, 8'h03: port id for the interrupt mask register (read/write).
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `address`  in  8  CPU `port_id`.
- `value_in`  in  8  CPU `out_port`; used for mask writes.
- `wen`  in  1  CPU `write_strobe`.
- `ren`  in  1  CPU `read_strobe`.
- `port_in`  in  8  asynchronous external pins.
- `value_out`  out  8  registered read data; 8'h00 when not addressed.
- `irq`  out  1  registered interrupt request, active high.

## Operation
- Sync chain per bit: `s1 <= port_in`, `s2 <= s1`, `s3 <= s2`. Edge pulse `e = s2 & ~s3`.
- Warm-up: a 2-bit counter counts 0 to 3 after reset and saturates. `e` is ignored until the counter equals 3, so pins held high through reset produce no flag.
- Edge flags `ef`: each clock, `ef <= (ef & ~clr) | (armed ? e : 0)`. `clr = value_out` when `ren && address == EADDR`; otherwise `clr = 0`. A set and a clear on the same bit in the same cycle leave the bit set, so no edge is lost.
- Mask `mask`: `mask <= value_in` when `wen && address == MADDR`. Writes to other addresses are ignored.
- `irq <= |(ef_next & mask)`, computed from the next-state flags.
- Read mux, registered every clock:
  - `address == ADDR`: `value_out <= s2`.
  - `address == EADDR`: `value_out <= ef`.
  - `address == MADDR`: `value_out <= mask`.
  - Otherwise `value_out <= 8'h00`.
- Address decode uses ADDR first, then EADDR, then MADDR. If parameters collide, the first match wins.
- Reset values: `s1`, `s2`, `s3`, `ef`, `mask`, `value_out` = 8'h00; `irq` = 0; warm-up counter = 0.
- Reset mid-operation clears all state on the next clock edge, including pending flags and `irq`.

## Timing
- Pin change sampled at edge k: `s2` reflects it after edge k+1; `ef` bit sets at edge k+2; `irq` asserts at edge k+2, because it uses `ef_next`.
- `value_out` has a latency of one clock from `address`. PacoBlaze3 holds `port_id` for 2 cycles and samples `in_port` at the end of the `ren` cycle, so data is valid when sampled.
- Clear on read takes effect at the same edge the CPU samples `value_out`. `irq` deasserts at that edge if no masked flags remain.
- Mask writes take effect at the `wen` edge. `irq` reflects the new mask at that same edge.
- Pulses shorter than one clock period may be missed. No debounce is performed.

## Structure
- Address constants (`PORTA`, and new `PORTB_DATA`, `PORTB_EDGE`, `PORTB_MASK`) live in the shared `gio.v` include alongside `outport`.
- Width comes from `` `operand_width`` in `pacoblaze_inc.v`.
- One sub-module is natural: `gio_sync`, an 8-bit 3-stage synchroniser plus rising-edge pulse generator with warm-up gating.
- The top level instantiates `inport_irq` next to `outport`, with `value_out` driving `pin` (OR-ed if more input peripherals are added).

## Test plan
- Reset with `port_in` = 8'hFF held: after 10 clocks, `ef` = 8'h00 and `irq` = 0. Reading ADDR returns 8'hFF.
- Mask 8'h01 written to MADDR; `port_in` bit0 goes 0→1 at edge k: `ef` = 8'h01 at k+2 and `irq` = 1 at k+2. Reading EADDR returns 8'h01, after which `ef` = 0 and `irq` = 0.
- Mask 8'h00; `port_in` goes 8'h00→8'h0F: `ef` = 8'h0F and `irq` stays 0. Writing mask 8'h04 raises `irq` at the write edge.
- Bit1 rising edge lands on the exact clock where a read clears `ef` = 8'h02: `ef` remains 8'h02 and `irq` stays asserted.
- `address` = 8'h10 with `ren` pulsed: `value_out` = 8'h00 and no flag changes. Read MADDR after writing 8'hA5 returns 8'hA5.
- `rst` asserted while `ef` = 8'hFF and `irq` = 1: the next edge gives all outputs = 0. A pin rising during warm-up sets no flag.

Source files
------------

// File: rtl/inport_irq_pkg.sv
// Shared constants and helpers for the PacoBlaze3 interrupting input port.
package inport_irq_pkg;

    // Operand width of the PacoBlaze3 I/O bus.
    localparam int unsigned DATA_W = 8;

    // Default port ids: live pin levels, sticky edge flags, interrupt mask.
    localparam logic [7:0] PORTB_DATA = 8'h01;
    localparam logic [7:0] PORTB_EDGE = 8'h02;
    localparam logic [7:0] PORTB_MASK = 8'h03;

    // Which register the current port id selects.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DATA = 2'd1,
        SEL_EDGE = 2'd2,
        SEL_MASK = 2'd3
    } port_sel_e;

    // Priority decode: data id wins over edge id, edge id over mask id,
    // so colliding parameters still give one well-defined selection.
    function automatic port_sel_e decode_port(
        input logic [7:0] address,
        input logic [7:0] a_data,
        input logic [7:0] a_edge,
        input logic [7:0] a_mask
    );
        port_sel_e sel;
        if (address == a_data) begin
            sel = SEL_DATA;
        end else if (address == a_edge) begin
            sel = SEL_EDGE;
        end else if (address == a_mask) begin
            sel = SEL_MASK;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/inport_irq_sync.sv
// Three-stage pin synchroniser with a rising-edge pulse that stays silent
// until the chain has been refilled after reset, so pins already high at
// reset release are not mistaken for edges.
module inport_irq_sync
    import inport_irq_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pins,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_r;
    logic [W-1:0] s2_r;
    logic [W-1:0] s3_r;
    logic [1:0]   warm_cnt_r;
    logic         armed_s;
    logic [W-1:0] rise_s;

    // Synchroniser chain and saturating warm-up counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r       <= {W{1'b0}};
            s2_r       <= {W{1'b0}};
            s3_r       <= {W{1'b0}};
            warm_cnt_r <= 2'd0;
        end else begin
            s1_r <= pins;
            s2_r <= s1_r;
            s3_r <= s2_r;
            if (warm_cnt_r != 2'd3) begin
                warm_cnt_r <= warm_cnt_r + 2'd1;
            end else begin
                warm_cnt_r <= warm_cnt_r;
            end
        end
    end

    // Rising-edge pulse, gated off while the chain is still warming up.
    always_comb begin
        armed_s = (warm_cnt_r == 2'd3);
        rise_s  = {W{1'b0}};
        if (armed_s) begin
            rise_s = s2_r & ~s3_r;
        end else begin
            rise_s = {W{1'b0}};
        end
    end

    assign level = s2_r;
    assign rise  = rise_s;

endmodule

// File: rtl/inport_irq.sv
// Memory-mapped input port for the PacoBlaze3 I/O bus: live pin levels,
// sticky rising-edge flags cleared by reading them, and a maskable
// interrupt. value_out is zero when unaddressed so it can be OR-ed onto
// the CPU in_port together with other peripherals.
module inport_irq
    import inport_irq_pkg::*;
#(
    parameter logic [7:0] ADDR  = PORTB_DATA,
    parameter logic [7:0] EADDR = PORTB_EDGE,
    parameter logic [7:0] MADDR = PORTB_MASK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        address,
    input  logic [DATA_W-1:0] value_in,
    input  logic              wen,
    input  logic              ren,
    input  logic [DATA_W-1:0] port_in,
    output logic [DATA_W-1:0] value_out,
    output logic              irq
);

    logic [DATA_W-1:0] level_s;
    logic [DATA_W-1:0] rise_s;
    port_sel_e         sel_s;
    logic [DATA_W-1:0] clr_s;
    logic [DATA_W-1:0] ef_next_s;
    logic [DATA_W-1:0] mask_next_s;
    logic              irq_next_s;
    logic [DATA_W-1:0] rdata_s;

    logic [DATA_W-1:0] ef_r;
    logic [DATA_W-1:0] mask_r;
    logic [DATA_W-1:0] value_out_r;
    logic              irq_r;

    inport_irq_sync #(
        .W(DATA_W)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .pins (port_in),
        .level(level_s),
        .rise (rise_s)
    );

    // Next-state logic: decode, clear-on-read, mask update, irq, read mux.
    // Only flags the CPU actually received (value_out) are cleared, and a
    // new edge in the same cycle wins over the clear.
    always_comb begin
        sel_s       = decode_port(address, ADDR, EADDR, MADDR);
        clr_s       = {DATA_W{1'b0}};
        mask_next_s = mask_r;
        rdata_s     = {DATA_W{1'b0}};

        if (ren && (sel_s == SEL_EDGE)) begin
            clr_s = value_out_r;
        end else begin
            clr_s = {DATA_W{1'b0}};
        end

        ef_next_s = (ef_r & ~clr_s) | rise_s;

        if (wen && (sel_s == SEL_MASK)) begin
            mask_next_s = value_in;
        end else begin
            mask_next_s = mask_r;
        end

        irq_next_s = |(ef_next_s & mask_next_s);

        case (sel_s)
            SEL_DATA: rdata_s = level_s;
            SEL_EDGE: rdata_s = ef_r;
            SEL_MASK: rdata_s = mask_r;
            default:  rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ef_r        <= {DATA_W{1'b0}};
            mask_r      <= {DATA_W{1'b0}};
            value_out_r <= {DATA_W{1'b0}};
            irq_r       <= 1'b0;
        end else begin
            ef_r        <= ef_next_s;
            mask_r      <= mask_next_s;
            value_out_r <= rdata_s;
            irq_r       <= irq_next_s;
        end
    end

    assign value_out = value_out_r;
    assign irq       = irq_r;

endmodule

// File: tb/tb_inport_irq.sv
// Scoreboard bench for inport_irq: stimulus pushes expected value_out/irq
// values tagged with the clock edge they must appear after; a monitor on
// the falling edge pops and compares them.
module tb_inport_irq;

    logic       clk;
    logic       rst;
    logic [7:0] address;
    logic [7:0] value_in;
    logic       wen;
    logic       ren;
    logic [7:0] port_in;
    logic [7:0] value_out;
    logic       irq;

    inport_irq dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .value_in (value_in),
        .wen      (wen),
        .ren      (ren),
        .port_in  (port_in),
        .value_out(value_out),
        .irq      (irq)
    );

    localparam logic [7:0] A_DATA = 8'h01;
    localparam logic [7:0] A_EDGE = 8'h02;
    localparam logic [7:0] A_MASK = 8'h03;
    localparam bit K_VO  = 1'b0;
    localparam bit K_IRQ = 1'b1;

    typedef struct {
        int         cyc;
        bit         kind;
        logic [7:0] val;
        string      name;
    } chk_t;

    chk_t sb_q[$];
    int   rd_idx = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   finish_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: cyc == n after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        logic [7:0] act;
        while (rd_idx < sb_q.size() && sb_q[rd_idx].cyc <= cyc) begin
            act = (sb_q[rd_idx].kind == K_IRQ) ? {7'd0, irq} : value_out;
            checks++;
            if (sb_q[rd_idx].cyc != cyc || act !== sb_q[rd_idx].val) begin
                errors++;
                $display("FAIL %s: got %h expected %h (edge %0d, due %0d)",
                         sb_q[rd_idx].name, act, sb_q[rd_idx].val, cyc, sb_q[rd_idx].cyc);
            end
            rd_idx++;
        end
        if (finish_req) begin
            while (rd_idx < sb_q.size()) begin
                checks++;
                errors++;
                $display("FAIL %s: never compared, expected %h", sb_q[rd_idx].name, sb_q[rd_idx].val);
                rd_idx++;
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a value 'ahead' rising edges from now (0 = the edge just passed).
    task automatic push(input bit kind, input logic [7:0] val, input int ahead, input string nm);
        chk_t c;
        c.cyc  = cyc + ahead;
        c.kind = kind;
        c.val  = val;
        c.name = nm;
        sb_q.push_back(c);
    endtask

    initial begin
        rst = 1'b1; port_in = 8'hFF; address = 8'h00; value_in = 8'h00; wen = 1'b0; ren = 1'b0;
        tick(); tick();
        push(K_IRQ, 8'h00, 0, "rst_irq");
        push(K_VO,  8'h00, 0, "rst_vo");
        rst = 1'b0;
        repeat (10) tick();
        // Pins held high through reset: no flags, live level visible.
        push(K_IRQ, 8'h00, 0, "warm_irq");
        address = A_EDGE; push(K_VO, 8'h00, 1, "warm_ef"); tick();
        address = A_DATA; push(K_VO, 8'hFF, 1, "live_ff"); tick();
        address = A_MASK; push(K_VO, 8'h00, 1, "mask_rst"); tick();

        // Mask 01, bit0 rises: flag and irq two edges after sampling.
        port_in = 8'hFE; address = A_MASK; wen = 1'b1; value_in = 8'h01; tick();
        wen = 1'b0; address = 8'h00;
        repeat (4) tick();
        port_in = 8'hFF; tick();
        push(K_IRQ, 8'h00, 0, "irq_k"); tick();
        push(K_IRQ, 8'h00, 0, "irq_k1"); tick();
        push(K_IRQ, 8'h01, 0, "irq_k2");
        address = A_EDGE; push(K_VO, 8'h01, 1, "ef_k3"); tick();
        ren = 1'b1; push(K_VO, 8'h01, 1, "rd_data"); tick();
        push(K_IRQ, 8'h00, 0, "irq_clr");
        ren = 1'b0; push(K_VO, 8'h00, 1, "ef_clr"); tick();

        // Mask 00, nibble rises: flags set, irq quiet until mask write.
        port_in = 8'h00; address = A_MASK; wen = 1'b1; value_in = 8'h00; tick();
        wen = 1'b0; address = 8'h00;
        repeat (4) tick();
        port_in = 8'h0F; repeat (4) tick();
        push(K_IRQ, 8'h00, 0, "masked_irq");
        address = A_EDGE; push(K_VO, 8'h0F, 1, "ef_0f"); tick();
        address = A_MASK; wen = 1'b1; value_in = 8'h04; tick();
        push(K_IRQ, 8'h01, 0, "irq_mask_wr");
        wen = 1'b0;
        address = A_EDGE; push(K_VO, 8'h0F, 1, "ef_0f_again"); tick();
        ren = 1'b1; tick();
        push(K_IRQ, 8'h00, 0, "irq_clr2");
        ren = 1'b0;

        // Bit1 edge coincides with clear-on-read of ef=02.
        address = 8'h00; port_in = 8'h0D; repeat (4) tick();
        address = A_MASK; wen = 1'b1; value_in = 8'h02; tick();
        wen = 1'b0; address = 8'h00;
        port_in = 8'h0F; tick();
        port_in = 8'h0D; tick();
        port_in = 8'h0F; address = A_EDGE; push(K_VO, 8'h00, 1, "ef_pre"); tick();
        push(K_IRQ, 8'h01, 0, "irq_first");
        push(K_VO, 8'h02, 1, "ef_first"); tick();
        ren = 1'b1; push(K_VO, 8'h02, 1, "rd_coincide"); tick();
        push(K_IRQ, 8'h01, 0, "irq_kept");
        ren = 1'b0; push(K_VO, 8'h02, 1, "ef_kept"); tick();
        ren = 1'b1; tick();
        push(K_IRQ, 8'h00, 0, "irq_clr3");
        ren = 1'b0; push(K_VO, 8'h00, 1, "ef_clr3"); tick();

        // Unmapped read leaves flags alone; mask readback; stray write ignored.
        port_in = 8'h1F; address = 8'h00; repeat (4) tick();
        address = 8'h10; ren = 1'b1; push(K_VO, 8'h00, 1, "unmapped"); tick();
        ren = 1'b0;
        address = A_EDGE; push(K_VO, 8'h10, 1, "ef_unchanged"); tick();
        address = A_MASK; wen = 1'b1; value_in = 8'hA5; tick();
        push(K_IRQ, 8'h00, 0, "irq_a5");
        address = 8'h10; value_in = 8'hFF; tick();
        wen = 1'b0;
        address = A_MASK; push(K_VO, 8'hA5, 1, "mask_a5"); tick();

        // All flags set with irq high, then reset mid-operation.
        address = 8'h00; port_in = 8'h00; repeat (4) tick();
        port_in = 8'hFF; repeat (4) tick();
        push(K_IRQ, 8'h01, 0, "irq_full");
        address = A_EDGE; push(K_VO, 8'hFF, 1, "ef_ff"); tick();
        rst = 1'b1; port_in = 8'h00; push(K_VO, 8'h00, 1, "rst_mid_vo"); tick();
        push(K_IRQ, 8'h00, 0, "rst_mid_irq");
        // Pin rises during warm-up: must not set a flag.
        rst = 1'b0; port_in = 8'hFF; repeat (5) tick();
        address = A_MASK; wen = 1'b1; value_in = 8'hFF; tick();
        push(K_IRQ, 8'h00, 0, "warm_irq2");
        wen = 1'b0;
        address = A_EDGE; push(K_VO, 8'h00, 1, "warm_ef2"); tick();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20; i++) begin
            if (rd_idx >= sb_q.size()) break;
            tick();
        end
        finish_req = 1'b1;
        repeat (3) tick();
        $display("FAIL monitor: summary not reached");
        $fatal(1);
    end

endmodule
